spike_event_fifo: RTL and testbench
===================================

// Module: spike_event_fifo
// PURPOSE
//  Downstream consumer of the LIF neuron's 1-bit spike output.
//  Timestamps every spike with a free-running timestep counter and buffers the timestamps in a FWFT FIFO.
//  Timestamps drain to a readout port over a valid/ready handshake.
//  Also measures spike rate over fixed windows and reports dropped events.
//  Sits between the neuron core and the output mux / host readout.
// PARAMETERS
//  TS_WIDTH  16  timestamp width; timestep counter wraps at 2^TS_WIDTH
//  DEPTH     8   FIFO entries; power of 2, >=2
//  WIN_LOG2  8   rate window length = 2^WIN_LOG2 cycles
// PORTS
//  clk          in   1            single clock, all logic on posedge
//  rst          in   1            reset: synchronous, active-high
//  spike_in     in   1            neuron spike, level, sampled every cycle
//  clear_stats  in   1            sync pulse: clears overflow and drop_cnt
//  ev_valid     out  1            FIFO non-empty
//  ev_ready     in   1            consumer accepts head entry
//  ev_ts        out  TS_WIDTH     timestamp at FIFO head
//  fifo_count   out  $clog2(DEPTH)+1  entries held, 0..DEPTH
//  overflow     out  1            sticky: a spike was dropped
//  drop_cnt     out  8            dropped spikes, saturates at 255
//  rate         out  8            spikes in last completed window, saturating
//  rate_valid   out  1            1-cycle pulse when rate updates
// BEHAVIOUR
//  Clocking: one clock; reset is synchronous and active-high.
//  Reset: ts counter, FIFO pointers, fifo_count, overflow, drop_cnt, rate, window counters all cleared to 0.
//   Reset also forces ev_valid=0 and rate_valid=0. Reset mid-operation discards FIFO contents; no partial state survives.
//  Timestep: ts increments by 1 every non-reset cycle, wraps max->0. First cycle after reset has ts=0.
//  Capture: every cycle with spike_in=1 is one event; no edge detect. Push value = ts of that same cycle.
//  FIFO is first-word-fall-through. Entry pushed at edge k gives ev_valid=1 and ev_ts valid after edge k (latency 1).
//  Pop occurs when ev_valid && ev_ready at an edge. ev_ts and ev_valid hold stable while ev_valid && !ev_ready.
//  Ordering: strict FIFO, oldest timestamp first.
//  Empty + push: entry accepted. ev_ready is ignored while empty.
//  Full + push + pop, same cycle: both occur, count stays DEPTH, no drop.
//  Full + push, no pop: spike dropped. overflow<=1; drop_cnt+1, saturating at 255.
//  Simultaneous push+pop otherwise: fifo_count unchanged.
//  clear_stats: clears overflow and drop_cnt. A drop in the same cycle wins: overflow=1, drop_cnt=1.
//  Rate: win_cnt (WIN_LOG2 bits) counts 0..2^WIN_LOG2-1. spk_cnt counts spike_in cycles, saturating at 255.
//   Dropped spikes are included in spk_cnt.
//   On a cycle with win_cnt at max: rate <= spk_cnt + spike_in (saturating); rate_valid=1 for one cycle.
//   spk_cnt restarts at 0 and win_cnt wraps to 0.
//  Widths: all counters unsigned. No other wrap/saturation besides those stated.
// TESTING
//  T1 reset; spike_in=1 at ts=5, ev_ready=1 -> next cycle ev_valid=1, ev_ts=5; popped after one cycle, fifo_count 1->0.
//  T2 DEPTH=8, ev_ready=0, spikes at ts 2,4,..,20 (10 spikes) -> fifo_count=8, overflow=1, drop_cnt=2.
//   Draining then yields ts 2,4,..,16 in order.
//  T3 FIFO full, spike_in=1 and ev_ready=1 same cycle -> no drop, fifo_count stays 8, drop_cnt unchanged.
//  T4 WIN_LOG2=4, spikes at ts 1,3,5,7,15 -> rate=5 with rate_valid high only in the ts=15 cycle.
//   The next window starts its count from 0.
//  T5 TS_WIDTH=4, spikes at ts 15 and at the following ts 1 -> ev_ts reads 15 then 1 (wrap).
//  T6 3 entries held, overflow=1; assert rst 1 cycle -> ev_valid=0, fifo_count=0, overflow=0, rate=0.
//   ts=0 on the first cycle after reset.

Source files
------------

// File: rtl/spike_event_fifo_if.sv
// Readout handshake for spike timestamps: the FIFO side is the master, the
// host-side consumer is the slave.
interface spike_event_fifo_if #(
  parameter int unsigned TS_WIDTH = 16
);
  logic                ev_valid;
  logic                ev_ready;
  logic [TS_WIDTH-1:0] ev_ts;

  modport master (
    output ev_valid,
    output ev_ts,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_ts,
    output ev_ready
  );
endinterface

// File: rtl/spike_event_fifo.sv
// Timestamps each LIF spike, buffers timestamps in a first-word-fall-through FIFO,
// counts dropped events and reports the spike rate per fixed window.
module spike_event_fifo #(
  parameter int unsigned TS_WIDTH = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WIN_LOG2 = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     spike_in,
  input  logic                     clear_stats,
  spike_event_fifo_if.master       ev,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  output logic [7:0]               rate,
  output logic                     rate_valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [TS_WIDTH-1:0] ts;
  logic [TS_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;

  logic                full;
  logic                pop;
  logic                push;
  logic                drop;

  logic [WIN_LOG2-1:0] win_cnt;
  logic [7:0]          spk_cnt;
  logic [7:0]          spk_next;
  logic                win_end;

  assign ev.ev_valid = !rst && (count != '0);
  assign ev.ev_ts    = mem[rd_ptr];
  assign fifo_count  = count;
  assign rate_valid  = !rst && win_end;

  // A pop frees the slot the same cycle, so a full FIFO still accepts a push then.
  always_comb begin
    full     = (count == CNT_W'(DEPTH));
    pop      = ev.ev_valid && ev.ev_ready;
    push     = spike_in && (!full || pop);
    drop     = spike_in && full && !pop;
    win_end  = (win_cnt == '1);
    spk_next = (spike_in && (spk_cnt != 8'hFF)) ? spk_cnt + 8'd1 : spk_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ts;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A drop in the same cycle as clear_stats restarts the statistics at one drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_stats) begin
        drop_cnt <= 8'd1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (clear_stats) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
      spk_cnt <= '0;
      rate    <= '0;
    end else begin
      win_cnt <= win_cnt + WIN_LOG2'(1);
      if (win_end) begin
        rate    <= spk_next;
        spk_cnt <= '0;
      end else begin
        spk_cnt <= spk_next;
      end
    end
  end

endmodule

// File: tb/tb_spike_event_fifo.sv
// Directed bench for spike_event_fifo: one default-sized instance and one
// narrow instance (4-bit timestamps, 16-cycle rate window).
module tb_spike_event_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, spike_a, clr_a;
  logic [3:0] cnt_a;
  logic       ovf_a, rv_a;
  logic [7:0] drop_a, rate_a;

  logic       rst_b, spike_b, clr_b;
  logic [3:0] cnt_b;
  logic       ovf_b, rv_b;
  logic [7:0] drop_b, rate_b;

  spike_event_fifo_if #(.TS_WIDTH(16)) ev_a ();
  spike_event_fifo_if #(.TS_WIDTH(4))  ev_b ();

  spike_event_fifo #(.TS_WIDTH(16), .DEPTH(8), .WIN_LOG2(8)) dut_a (
    .clk         (clk),
    .rst         (rst_a),
    .spike_in    (spike_a),
    .clear_stats (clr_a),
    .ev          (ev_a),
    .fifo_count  (cnt_a),
    .overflow    (ovf_a),
    .drop_cnt    (drop_a),
    .rate        (rate_a),
    .rate_valid  (rv_a)
  );

  spike_event_fifo #(.TS_WIDTH(4), .DEPTH(8), .WIN_LOG2(4)) dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .spike_in    (spike_b),
    .clear_stats (clr_b),
    .ev          (ev_b),
    .fifo_count  (cnt_b),
    .overflow    (ovf_b),
    .drop_cnt    (drop_b),
    .rate        (rate_b),
    .rate_valid  (rv_b)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
  endtask

  task automatic reset_b();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; spike_a = 1'b0; clr_a = 1'b0; ev_a.ev_ready = 1'b0;
    rst_b = 1'b1; spike_b = 1'b0; clr_b = 1'b0; ev_b.ev_ready = 1'b0;

    // T1: reset state, then a single spike at ts=5 with the consumer ready
    reset_a();
    chk("rst valid", ev_a.ev_valid, 0);
    chk("rst count", cnt_a, 0);
    chk("rst ovf", ovf_a, 0);
    chk("rst drop", drop_a, 0);
    chk("rst rate", rate_a, 0);
    chk("rst rv", rv_a, 0);
    repeat (5) tick();
    spike_a = 1'b1; ev_a.ev_ready = 1'b1;
    tick();
    spike_a = 1'b0;
    chk("t1 valid", ev_a.ev_valid, 1);
    chk("t1 ts", ev_a.ev_ts, 5);
    chk("t1 count", cnt_a, 1);
    tick();
    chk("t1 popped valid", ev_a.ev_valid, 0);
    chk("t1 popped count", cnt_a, 0);

    // T2: spikes at ts 2,4,..,20 with no consumer -> two drops
    ev_a.ev_ready = 1'b0;
    reset_a();
    for (int t = 0; t <= 20; t++) begin
      spike_a = (t >= 2) && (t % 2 == 0);
      tick();
    end
    spike_a = 1'b0;
    chk("t2 count", cnt_a, 8);
    chk("t2 ovf", ovf_a, 1);
    chk("t2 drop", drop_a, 2);
    chk("t2 head", ev_a.ev_ts, 2);

    // clear_stats colliding with a drop keeps the new drop
    spike_a = 1'b1; clr_a = 1'b1;
    tick();
    chk("clr+drop cnt", drop_a, 1);
    chk("clr+drop ovf", ovf_a, 1);
    chk("clr+drop count", cnt_a, 8);
    spike_a = 1'b0;
    tick();
    clr_a = 1'b0;
    chk("clr drop", drop_a, 0);
    chk("clr ovf", ovf_a, 0);

    // T3: full + push + pop in the same cycle (current ts=23)
    spike_a = 1'b1; ev_a.ev_ready = 1'b1;
    tick();
    spike_a = 1'b0; ev_a.ev_ready = 1'b0;
    chk("t3 count", cnt_a, 8);
    chk("t3 drop", drop_a, 0);
    chk("t3 ovf", ovf_a, 0);
    chk("t3 head", ev_a.ev_ts, 4);
    tick();
    chk("t3 hold ts", ev_a.ev_ts, 4);
    chk("t3 hold valid", ev_a.ev_valid, 1);

    // drain in order
    ev_a.ev_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("drain ts", ev_a.ev_ts, 4 + 2 * i);
      tick();
    end
    chk("drain last ts", ev_a.ev_ts, 23);
    tick();
    chk("drain empty valid", ev_a.ev_valid, 0);
    chk("drain empty count", cnt_a, 0);
    ev_a.ev_ready = 1'b0;

    // Saturation: 256 spike cycles fill one full rate window and overflow the FIFO
    reset_a();
    spike_a = 1'b1;
    for (int t = 0; t < 256; t++) begin
      if (t == 254) chk("sat rv pre", rv_a, 0);
      if (t == 255) chk("sat rv end", rv_a, 1);
      tick();
    end
    chk("sat rate", rate_a, 255);
    chk("sat rv after", rv_a, 0);
    chk("sat drop 248", drop_a, 248);
    repeat (10) tick();
    chk("sat drop 255", drop_a, 255);

    // T6: three entries held with overflow set, then a one-cycle reset
    spike_a = 1'b0; ev_a.ev_ready = 1'b1;
    repeat (5) tick();
    ev_a.ev_ready = 1'b0;
    chk("t6 count pre", cnt_a, 3);
    chk("t6 ovf pre", ovf_a, 1);
    reset_a();
    chk("t6 valid", ev_a.ev_valid, 0);
    chk("t6 count", cnt_a, 0);
    chk("t6 ovf", ovf_a, 0);
    chk("t6 drop", drop_a, 0);
    chk("t6 rate", rate_a, 0);
    spike_a = 1'b1;
    tick();
    spike_a = 1'b0;
    chk("t6 first ts", ev_a.ev_ts, 0);
    chk("t6 first count", cnt_a, 1);

    // T4: 16-cycle window, spikes at 1,3,5,7,15
    reset_b();
    ev_b.ev_ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      spike_b = (t == 1) || (t == 3) || (t == 5) || (t == 7) || (t == 15);
      chk("t4 rv", rv_b, (t == 15) ? 1 : 0);
      tick();
    end
    spike_b = 1'b0;
    chk("t4 rate", rate_b, 5);
    chk("t4 rv after", rv_b, 0);
    for (int t = 0; t < 16; t++) begin
      spike_b = (t < 3);
      tick();
    end
    spike_b = 1'b0;
    chk("t4 next rate", rate_b, 3);

    // T5: 4-bit timestamps wrap from 15 to 0
    ev_b.ev_ready = 1'b0;
    reset_b();
    repeat (15) tick();
    spike_b = 1'b1;
    tick();
    spike_b = 1'b0;
    tick();
    spike_b = 1'b1;
    tick();
    spike_b = 1'b0;
    chk("t5 count", cnt_b, 2);
    chk("t5 ts 15", ev_b.ev_ts, 15);
    ev_b.ev_ready = 1'b1;
    tick();
    chk("t5 ts 1", ev_b.ev_ts, 1);
    tick();
    chk("t5 empty", ev_b.ev_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
